// File: rtl/irq_timer_scheduler.sv
// irq_timer_scheduler: memory-mapped timer and interrupt scheduler that drives the control unit IRQ input.
// Ports:
//   clk        system clock; all state changes on the rising edge
//   reset      asynchronous active-low reset
//   addr       data bus byte address; the window is 6 words at BASE_ADDR
//   wdata      data bus write data
//   MemWr      bus write strobe
//   MemRd      bus read strobe
//   rdata      combinational read data; 0 when not reading this window
//   ext_irq    asynchronous external interrupt lines, active high
//   pc_kernel  PC[31] of the current instruction; 1 = handler/kernel mode
//   IRQ        one-cycle interrupt request to the control unit
module irq_timer_scheduler #(
    parameter int          NUM_EXT   = 3,
    parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    input  logic               MemWr,
    input  logic               MemRd,
    output logic [31:0]        rdata,
    input  logic [NUM_EXT-1:0] ext_irq,
    input  logic               pc_kernel,
    output logic               IRQ
);
    localparam int NS = NUM_EXT + 1;

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t             state_q;
    logic [31:0]        th_q, th_d, tl_q, tl_d;
    logic [2:0]         tcon_q, tcon_d;
    logic [NS-1:0]      imask_q, imask_d, ipend_q, ipend_d;
    logic [NUM_EXT-1:0] sync1_q, sync2_q, prev_q;
    logic [2:0]         idx;
    logic               hit, timer_set, pend_any;
    logic [NS-1:0]      set_vec, active;
    logic [31:0]        isrc;

    // Window is word aligned; the top bits pick the block, [4:2] picks the register.
    assign idx = addr[4:2];
    assign hit = addr[31:5] == BASE_ADDR[31:5] && idx < 3'd6 && addr[1:0] == 2'b00;

    assign timer_set = tcon_q[0] && tl_q == 32'hFFFFFFFF && tcon_q[1];
    // Third flop after the synchroniser gives a one-cycle rising-edge pulse per line.
    assign set_vec   = {sync2_q & ~prev_q, timer_set};
    assign active    = ipend_q & imask_q;
    assign pend_any  = |active && tcon_q[2];
    assign IRQ       = state_q == REQ && !pc_kernel && pend_any;

    always_comb begin
        th_d    = MemWr && hit && idx == 3'd0 ? wdata : th_q;
        tl_d    = MemWr && hit && idx == 3'd1 ? wdata :
                  !tcon_q[0]                  ? tl_q  :
                  tl_q == 32'hFFFFFFFF        ? th_q  : tl_q + 32'd1;
        tcon_d  = MemWr && hit && idx == 3'd2 ? wdata[2:0] : tcon_q;
        imask_d = MemWr && hit && idx == 3'd3 ? wdata[NS-1:0] : imask_q;
        // Set after clear, so a same-cycle event survives a W1C of its bit.
        ipend_d = (ipend_q & ~(MemWr && hit && idx == 3'd4 ? wdata[NS-1:0] : '0)) | set_vec;
    end

    always_comb begin
        isrc = 32'hFFFFFFFF;
        for (int i = NS - 1; i >= 0; i--)
            if (active[i]) isrc = 32'(i);
    end

    always_comb begin
        rdata = '0;
        if (MemRd && hit)
            case (idx)
                3'd0:    rdata = th_q;
                3'd1:    rdata = tl_q;
                3'd2:    rdata = 32'(tcon_q);
                3'd3:    rdata = 32'(imask_q);
                3'd4:    rdata = 32'(ipend_q);
                default: rdata = isrc;
            endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            th_q    <= '0;
            tl_q    <= '0;
            tcon_q  <= '0;
            imask_q <= '0;
            ipend_q <= '0;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
        end else begin
            th_q    <= th_d;
            tl_q    <= tl_d;
            tcon_q  <= tcon_d;
            imask_q <= imask_d;
            ipend_q <= ipend_d;
            sync1_q <= ext_irq;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            case (state_q)
                IDLE:    if (pend_any && !pc_kernel) state_q <= REQ;
                // Losing the request (mask/enable cleared) or entering kernel mode aborts without IRQ.
                REQ:     state_q <= !pend_any || pc_kernel ? IDLE : SERVICE;
                SERVICE: if (!pc_kernel) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_timer_scheduler.sv
// tb_irq_timer_scheduler: directed self-checking bench for irq_timer_scheduler.
module tb_irq_timer_scheduler;
    localparam logic [31:0] BASE = 32'h40000000;
    localparam logic [31:0] TH = 32'h00, TL = 32'h04, TCON = 32'h08;
    localparam logic [31:0] IMASK = 32'h0C, IPEND = 32'h10, ISRC = 32'h14;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        MemWr = 1'b0, MemRd = 1'b0;
    logic [2:0]  ext_irq = '0;
    logic        pc_kernel = 1'b0;
    logic        IRQ;
    logic [31:0] d;
    int          n_checks = 0, n_fail = 0;

    irq_timer_scheduler #(.NUM_EXT(3), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset), .addr(addr), .wdata(wdata), .MemWr(MemWr), .MemRd(MemRd),
        .rdata(rdata), .ext_irq(ext_irq), .pc_kernel(pc_kernel), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        addr = BASE + off;
        wdata = data;
        MemWr = 1'b1;
        tick();
        MemWr = 1'b0;
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] data);
        addr = BASE + off;
        MemRd = 1'b1;
        #1;
        data = rdata;
        MemRd = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        check("irq_in_reset", {31'b0, IRQ}, 32'h0);
        rd(TL, d); check("tl_in_reset", d, 32'h0);
        reset = 1'b1;
        tick();
        rd(TCON, d); check("tcon_reset", d, 32'h0);
        rd(ISRC, d); check("isrc_reset", d, 32'hFFFFFFFF);

        // T1 timer wrap
        wr(TH, 32'hFFFFFFFC);
        wr(TL, 32'hFFFFFFFD);
        wr(IMASK, 32'h1);
        wr(TCON, 32'h7);
        rd(TL, d); check("t1_tl_fd", d, 32'hFFFFFFFD);
        tick();
        rd(TL, d); check("t1_tl_fe", d, 32'hFFFFFFFE);
        tick();
        rd(TL, d); check("t1_tl_ff", d, 32'hFFFFFFFF);
        rd(IPEND, d); check("t1_pend_pre", d, 32'h0);
        tick();
        rd(TL, d); check("t1_tl_reload", d, 32'hFFFFFFFC);
        rd(IPEND, d); check("t1_pend_set", d, 32'h1);
        rd(ISRC, d); check("t1_isrc", d, 32'h0);
        check("t1_irq_lat0", {31'b0, IRQ}, 32'h0);
        tick();
        check("t1_irq_pulse", {31'b0, IRQ}, 32'h1);
        tick();
        check("t1_irq_one", {31'b0, IRQ}, 32'h0);

        // T2 no nesting
        pc_kernel = 1'b1;
        tick();
        ext_irq = 3'b010;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_irq_kernel", {31'b0, IRQ}, 32'h0);
        end
        rd(IPEND, d); check("t2_pend", d, 32'h5);
        pc_kernel = 1'b0;
        tick();
        check("t2_irq_idle", {31'b0, IRQ}, 32'h0);
        tick();
        check("t2_irq_again", {31'b0, IRQ}, 32'h1);
        tick();
        check("t2_irq_drop", {31'b0, IRQ}, 32'h0);
        wr(TCON, 32'h0);
        ext_irq = 3'b000;
        wr(IPEND, 32'hF);
        tick();
        tick();
        tick();
        rd(IPEND, d); check("t2_cleared", d, 32'h0);

        // T3 W1C vs set
        wr(TL, 32'hFFFFFFFE);
        wr(TCON, 32'h3);
        rd(TL, d); check("t3_tl_fe", d, 32'hFFFFFFFE);
        tick();
        rd(TL, d); check("t3_tl_ff", d, 32'hFFFFFFFF);
        wr(IPEND, 32'h1);
        rd(IPEND, d); check("t3_set_wins", d, 32'h1);
        rd(TL, d); check("t3_tl_reload", d, 32'hFFFFFFFC);
        wr(IPEND, 32'h1);
        rd(IPEND, d); check("t3_w1c", d, 32'h0);
        wr(TCON, 32'h0);

        // T4 masking and ISRC
        ext_irq = 3'b101;
        tick();
        tick();
        tick();
        ext_irq = 3'b000;
        rd(IPEND, d); check("t4_pend", d, 32'hA);
        wr(IMASK, 32'h8);
        rd(ISRC, d); check("t4_isrc3", d, 32'h3);
        wr(IMASK, 32'hA);
        rd(ISRC, d); check("t4_isrc_low", d, 32'h1);
        wr(IMASK, 32'h0);
        rd(ISRC, d); check("t4_isrc_none", d, 32'hFFFFFFFF);
        wr(ISRC, 32'h0);
        rd(ISRC, d); check("t4_isrc_ro", d, 32'hFFFFFFFF);
        rd(32'h18, d); check("t4_unmapped", d, 32'h0);
        addr = BASE + IPEND;
        #1;
        check("t4_no_rd", rdata, 32'h0);
        wr(TCON, 32'h4);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t4_masked_irq", {31'b0, IRQ}, 32'h0);
        end

        // T5 edge detect
        wr(TCON, 32'h0);
        wr(IPEND, 32'hF);
        rd(IPEND, d); check("t5_clear", d, 32'h0);
        ext_irq = 3'b001;
        tick();
        tick();
        tick();
        rd(IPEND, d); check("t5_set", d, 32'h2);
        wr(IPEND, 32'h2);
        rd(IPEND, d); check("t5_cleared", d, 32'h0);
        for (int i = 0; i < 6; i++) tick();
        rd(IPEND, d); check("t5_held_level", d, 32'h0);
        ext_irq = 3'b000;
        tick();
        tick();
        tick();
        rd(IPEND, d); check("t5_fall", d, 32'h0);
        ext_irq = 3'b001;
        tick();
        tick();
        tick();
        rd(IPEND, d); check("t5_rise_again", d, 32'h2);
        ext_irq = 3'b000;

        // T6 reset mid-REQ
        wr(TCON, 32'h4);
        wr(IMASK, 32'h2);
        tick();
        check("t6_irq_req", {31'b0, IRQ}, 32'h1);
        reset = 1'b0;
        #1;
        check("t6_irq_async", {31'b0, IRQ}, 32'h0);
        tick();
        reset = 1'b1;
        tick();
        rd(TH, d); check("t6_th", d, 32'h0);
        rd(TL, d); check("t6_tl", d, 32'h0);
        rd(TCON, d); check("t6_tcon", d, 32'h0);
        rd(IMASK, d); check("t6_imask", d, 32'h0);
        rd(IPEND, d); check("t6_ipend", d, 32'h0);
        check("t6_irq_after", {31'b0, IRQ}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
